// File: rtl/ram_init_walker_if.sv
// Bus between the reset sequencer / pipeline write port and the RAM-init walker.
// master drives requests and pipeline writes; slave (the walker) drives the RAM port and status.
interface ram_init_walker_if #(
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned DATA_WIDTH  = 8
);
    logic                   resetRams_i;
    logic                   we_i;
    logic [INDEX_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0]  data_i;
    logic                   ramWe_o;
    logic [INDEX_WIDTH-1:0] ramAddr_o;
    logic [DATA_WIDTH-1:0]  ramData_o;
    logic                   initBusy_o;
    logic                   ramReady_o;

    modport master (
        output resetRams_i, we_i, addr_i, data_i,
        input  ramWe_o, ramAddr_o, ramData_o, initBusy_o, ramReady_o
    );

    modport slave (
        input  resetRams_i, we_i, addr_i, data_i,
        output ramWe_o, ramAddr_o, ramData_o, initBusy_o, ramReady_o
    );
endinterface

// File: rtl/ram_init_walker.sv
// Sweeps every RAM entry with a deterministic init value on request, then hands the
// RAM write port over to the pipeline and reports ready to the reset sequencer.
module ram_init_walker #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned INIT_MODE   = 0,
    parameter int unsigned INIT_OFFSET = 0
) (
    input logic              clk,
    input logic              reset,
    ram_init_walker_if.slave bus
);

    // Encoding chosen so busy and ready are each a single state flop bit.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StInit = 2'b01,
        StDone = 2'b10
    } walkState_e;

    localparam logic [INDEX_WIDTH-1:0] LastIdx = INDEX_WIDTH'(DEPTH - 1);

    walkState_e             stateQ, stateD;
    logic [INDEX_WIDTH-1:0] counterQ, counterD;

    function automatic logic [DATA_WIDTH-1:0] initValue(input logic [INDEX_WIDTH-1:0] idx);
        logic [DATA_WIDTH-1:0] idxExt;
        idxExt = DATA_WIDTH'(idx);
        case (INIT_MODE)
            1:       return idxExt;
            2:       return idxExt + DATA_WIDTH'(INIT_OFFSET);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= StIdle;
            counterQ <= '0;
        end else begin
            stateQ   <= stateD;
            counterQ <= counterD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        counterD = counterQ;
        case (stateQ)
            StIdle: begin
                if (bus.resetRams_i) begin
                    stateD   = StInit;
                    counterD = '0;
                end
            end
            StInit: begin
                // A new request always restarts the sweep, even on the last entry.
                if (bus.resetRams_i) begin
                    counterD = '0;
                end else if (counterQ == LastIdx) begin
                    stateD = StDone;
                end else begin
                    counterD = counterQ + INDEX_WIDTH'(1);
                end
            end
            StDone: begin
                if (bus.resetRams_i) begin
                    stateD   = StInit;
                    counterD = '0;
                end
            end
            default: begin
                stateD   = StIdle;
                counterD = '0;
            end
        endcase
    end

    always_comb begin
        bus.ramWe_o   = 1'b0;
        bus.ramAddr_o = '0;
        bus.ramData_o = '0;
        case (stateQ)
            StInit: begin
                bus.ramWe_o   = 1'b1;
                bus.ramAddr_o = counterQ;
                bus.ramData_o = initValue(counterQ);
            end
            StDone: begin
                bus.ramWe_o   = bus.we_i;
                bus.ramAddr_o = bus.addr_i;
                bus.ramData_o = bus.data_i;
            end
            default: ;
        endcase
    end

    assign bus.initBusy_o = stateQ[0];
    assign bus.ramReady_o = stateQ[1];

endmodule

// File: tb/tb_ram_init_walker.sv
// Directed bench for ram_init_walker: three instances (64-deep identity, 40-deep offset,
// 3-deep table-driven) sharing one clock and reset.
module tb_ram_init_walker;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ram_init_walker_if #(.INDEX_WIDTH(6), .DATA_WIDTH(8)) bus64 ();
    ram_init_walker_if #(.INDEX_WIDTH(6), .DATA_WIDTH(4)) bus40 ();
    ram_init_walker_if #(.INDEX_WIDTH(2), .DATA_WIDTH(8)) bus3 ();

    ram_init_walker #(
        .DEPTH(64), .INDEX_WIDTH(6), .DATA_WIDTH(8), .INIT_MODE(1), .INIT_OFFSET(0)
    ) dut64 (.clk(clk), .reset(reset), .bus(bus64));

    ram_init_walker #(
        .DEPTH(40), .INDEX_WIDTH(6), .DATA_WIDTH(4), .INIT_MODE(2), .INIT_OFFSET(10)
    ) dut40 (.clk(clk), .reset(reset), .bus(bus40));

    ram_init_walker #(
        .DEPTH(3), .INDEX_WIDTH(2), .DATA_WIDTH(8), .INIT_MODE(2), .INIT_OFFSET(200)
    ) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    typedef struct {
        bit         rr;
        bit         we;
        logic [1:0] a;
        logic [7:0] d;
        bit         eWe;
        logic [1:0] eA;
        logic [7:0] eD;
        bit         eB;
        bit         eR;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk5(input string tag, input logic aWe, input logic [31:0] aA,
                        input logic [31:0] aD, input logic aB, input logic aR,
                        input bit eWe, input int eA, input int eD, input bit eB, input bit eR);
        chk({tag, ".we"}, 32'(aWe), 32'(eWe));
        chk({tag, ".addr"}, aA, eA);
        chk({tag, ".data"}, aD, eD);
        chk({tag, ".busy"}, 32'(aB), 32'(eB));
        chk({tag, ".ready"}, 32'(aR), 32'(eR));
    endtask

    // Drive inputs just after a falling edge, check comb outputs before the next rising edge.
    task automatic cyc64(input string tag, input bit rr, input bit we, input int a, input int d,
                         input bit eWe, input int eA, input int eD, input bit eB, input bit eR);
        @(negedge clk);
        bus64.resetRams_i = rr;
        bus64.we_i        = we;
        bus64.addr_i      = 6'(a);
        bus64.data_i      = 8'(d);
        #1;
        chk5(tag, bus64.ramWe_o, 32'(bus64.ramAddr_o), 32'(bus64.ramData_o),
             bus64.initBusy_o, bus64.ramReady_o, eWe, eA, eD, eB, eR);
    endtask

    task automatic cyc40(input string tag, input bit rr,
                         input bit eWe, input int eA, input int eD, input bit eB, input bit eR);
        @(negedge clk);
        bus40.resetRams_i = rr;
        bus40.we_i        = 1'b0;
        bus40.addr_i      = '0;
        bus40.data_i      = '0;
        #1;
        chk5(tag, bus40.ramWe_o, 32'(bus40.ramAddr_o), 32'(bus40.ramData_o),
             bus40.initBusy_o, bus40.ramReady_o, eWe, eA, eD, eB, eR);
    endtask

    // Full 64-entry identity sweep starting at entry 0, then the first ready cycle.
    // Pipeline writes are offered throughout the sweep and must never reach the RAM.
    task automatic sweep64(input string tag);
        for (int k = 0; k < 64; k++) begin
            cyc64($sformatf("%s.e%0d", tag, k), 1'b0, 1'b1, 5, 8'hA5, 1'b1, k, k, 1'b1, 1'b0);
        end
        cyc64({tag, ".rdy"}, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0]  = '{1'b0, 1'b1, 2'd1, 8'h07, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'd2, 8'h09, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'd1, 8'h05, 1'b1, 2'd0, 8'd200, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'd201, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'd202, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'd200, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'd201, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'd202, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'd3, 8'h5A, 1'b1, 2'd3, 8'h5A,  1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 2'd1, 8'h11, 1'b0, 2'd1, 8'h11,  1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 2'd2, 8'h33, 1'b1, 2'd2, 8'h33,  1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 2'd1, 8'h44, 1'b1, 2'd0, 8'd200, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'd201, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'd202, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'd0,   1'b0, 1'b1};

        reset = 1'b1;
        bus64.resetRams_i = 1'b0; bus64.we_i = 1'b1; bus64.addr_i = 6'd5; bus64.data_i = 8'hA5;
        bus40.resetRams_i = 1'b0; bus40.we_i = 1'b0; bus40.addr_i = '0;   bus40.data_i = '0;
        bus3.resetRams_i  = 1'b0; bus3.we_i  = 1'b0; bus3.addr_i  = '0;   bus3.data_i  = '0;
        #1;
        chk5("rst64", bus64.ramWe_o, 32'(bus64.ramAddr_o), 32'(bus64.ramData_o),
             bus64.initBusy_o, bus64.ramReady_o, 1'b0, 0, 0, 1'b0, 1'b0);
        chk5("rst40", bus40.ramWe_o, 32'(bus40.ramAddr_o), 32'(bus40.ramData_o),
             bus40.initBusy_o, bus40.ramReady_o, 1'b0, 0, 0, 1'b0, 1'b0);
        chk5("rst3", bus3.ramWe_o, 32'(bus3.ramAddr_o), 32'(bus3.ramData_o),
             bus3.initBusy_o, bus3.ramReady_o, 1'b0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // IDLE ignores pipeline writes; then identity sweep of 64 entries.
        cyc64("idleWe", 1'b0, 1'b1, 5, 8'hA5, 1'b0, 0, 0, 1'b0, 1'b0);
        cyc64("t1.req", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        sweep64("t1");
        cyc64("t5.pass", 1'b0, 1'b1, 5, 8'hA5, 1'b1, 5, 8'hA5, 1'b0, 1'b1);

        // Request and pipeline write in the same DONE cycle; restart at entry 20.
        cyc64("t3.req", 1'b1, 1'b1, 7, 8'h3C, 1'b1, 7, 8'h3C, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            cyc64($sformatf("t3.p%0d", k), 1'b0, 1'b1, 5, 8'hA5, 1'b1, k, k, 1'b1, 1'b0);
        end
        cyc64("t3.req2", 1'b1, 1'b0, 0, 0, 1'b1, 20, 20, 1'b1, 1'b0);
        sweep64("t3");

        // Async reset in the middle of a sweep, then a fresh full sweep.
        cyc64("t4.req", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 30; k++) begin
            cyc64($sformatf("t4.p%0d", k), 1'b0, 1'b0, 0, 0, 1'b1, k, k, 1'b1, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk5("t4.rst", bus64.ramWe_o, 32'(bus64.ramAddr_o), 32'(bus64.ramData_o),
             bus64.initBusy_o, bus64.ramReady_o, 1'b0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc64($sformatf("t4.idle%0d", k), 1'b0, 1'b1, 5, 8'hA5, 1'b0, 0, 0, 1'b0, 1'b0);
        end
        cyc64("t4.req2", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        sweep64("t4");

        // Request held high for three cycles: each restarts at entry 0.
        cyc64("t6.h0", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        cyc64("t6.h1", 1'b1, 1'b0, 0, 0, 1'b1, 0, 0, 1'b1, 1'b0);
        cyc64("t6.h2", 1'b1, 1'b0, 0, 0, 1'b1, 0, 0, 1'b1, 1'b0);
        sweep64("t6");

        // 40 entries, 4-bit data, value (index + 10) mod 16.
        cyc40("t2.req", 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc40($sformatf("t2.e%0d", k), 1'b0, 1'b1, k, (k + 10) % 16, 1'b1, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc40($sformatf("t2.rdy%0d", k), 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        end

        // 3-deep instance: cycle-by-cycle table.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus3.resetRams_i = tbl[i].rr;
            bus3.we_i        = tbl[i].we;
            bus3.addr_i      = tbl[i].a;
            bus3.data_i      = tbl[i].d;
            #1;
            chk5($sformatf("tbl%0d", i), bus3.ramWe_o, 32'(bus3.ramAddr_o),
                 32'(bus3.ramData_o), bus3.initBusy_o, bus3.ramReady_o,
                 tbl[i].eWe, int'(tbl[i].eA), int'(tbl[i].eD), tbl[i].eB, tbl[i].eR);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
